// File: rtl/tile_dma_scheduler.sv
// Round-robin share of the single DMA channel between the A/B tile loaders
// and the C-tile writeback; issues each granted transfer one 256-bit beat at a time.
module tile_dma_scheduler #(
  parameter int BEAT_BYTES = 32,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [2:0]         req,
  input  logic [95:0]        req_addr,
  input  logic [3*CNT_W-1:0] req_beats,
  input  logic [2:0]         req_write,
  input  logic [767:0]       wr_data,
  output logic [2:0]         gnt,
  output logic [2:0]         done,
  output logic [255:0]       rd_data,
  output logic [2:0]         rd_valid,
  output logic [CNT_W-1:0]   beat_idx,
  output logic               busy,
  output logic               dma_start,
  output logic [31:0]        dma_addr,
  output logic               dma_write,
  output logic [255:0]       dma_wdata,
  input  logic               dma_done,
  input  logic [255:0]       dma_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_g;
  logic [1:0]       r_last;
  logic [2:0]       r_gnt;
  logic [2:0]       r_done;
  logic             r_dma_start;
  logic             r_busy;
  logic             r_dir;
  logic [31:0]      r_cur_addr;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_beat_idx;

  logic             w_win_vld;
  logic [1:0]       w_win;
  logic [2:0]       w_win_oh;
  logic [31:0]      w_addr;
  logic [CNT_W-1:0] w_beats;
  logic             w_write;
  logic [255:0]     w_wdata;

  // Search starts just after the last served requester, wrapping.
  always_comb begin
    w_win_vld = |req;
    w_win     = 2'd0;
    unique case (r_last)
      2'd0: begin
        if (req[1])      w_win = 2'd1;
        else if (req[2]) w_win = 2'd2;
        else             w_win = 2'd0;
      end
      2'd1: begin
        if (req[2])      w_win = 2'd2;
        else if (req[0]) w_win = 2'd0;
        else             w_win = 2'd1;
      end
      default: begin
        if (req[0])      w_win = 2'd0;
        else if (req[1]) w_win = 2'd1;
        else             w_win = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_win_oh = 3'b001;
    w_addr   = req_addr[31:0];
    w_beats  = req_beats[CNT_W-1:0];
    w_write  = req_write[0];
    unique case (w_win)
      2'd1: begin
        w_win_oh = 3'b010;
        w_addr   = req_addr[63:32];
        w_beats  = req_beats[2*CNT_W-1:CNT_W];
        w_write  = req_write[1];
      end
      2'd2: begin
        w_win_oh = 3'b100;
        w_addr   = req_addr[95:64];
        w_beats  = req_beats[3*CNT_W-1:2*CNT_W];
        w_write  = req_write[2];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_wdata = wr_data[255:0];
    unique case (r_g)
      2'd1:    w_wdata = wr_data[511:256];
      2'd2:    w_wdata = wr_data[767:512];
      default: w_wdata = wr_data[255:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_g         <= 2'd0;
      r_last      <= 2'd2;
      r_gnt       <= '0;
      r_done      <= '0;
      r_dma_start <= 1'b0;
      r_busy      <= 1'b0;
      r_dir       <= 1'b0;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_beat_idx  <= '0;
    end else begin
      r_done      <= '0;
      r_dma_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_win_vld) begin
            r_g         <= w_win;
            r_gnt       <= w_win_oh;
            r_cur_addr  <= w_addr;
            r_remaining <= w_beats;
            r_dir       <= w_write;
            r_beat_idx  <= '0;
            r_busy      <= 1'b1;
            if (w_beats == '0) begin
              r_state <= S_DONE;
              r_done  <= w_win_oh;
            end else begin
              r_state     <= S_ISSUE;
              r_dma_start <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dma_done) begin
            r_cur_addr  <= r_cur_addr + 32'(BEAT_BYTES);
            r_remaining <= r_remaining - CNT_W'(1);
            r_beat_idx  <= r_beat_idx + CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= r_gnt;
            end else begin
              r_state     <= S_ISSUE;
              r_dma_start <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_last  <= r_g;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign busy      = r_busy;
  assign dma_start = r_dma_start;
  assign dma_addr  = r_cur_addr;
  assign dma_write = r_dir;
  assign dma_wdata = w_wdata;
  assign beat_idx  = r_beat_idx;
  assign rd_data   = dma_rdata;
  assign rd_valid  = (dma_done && r_state == S_WAIT && !r_dir)
                   ? r_gnt : 3'b000;

endmodule

// File: tb/tb_tile_dma_scheduler.sv
// Directed bench for tile_dma_scheduler: read, round-robin, write,
// zero-beat, address wrap, stray dma_done and mid-transfer reset.
module tb_tile_dma_scheduler;

  logic         clk = 1'b0;
  logic         rstn;
  logic [2:0]   req;
  logic [95:0]  req_addr;
  logic [47:0]  req_beats;
  logic [2:0]   req_write;
  logic [767:0] wr_data;
  logic [2:0]   gnt;
  logic [2:0]   done;
  logic [255:0] rd_data;
  logic [2:0]   rd_valid;
  logic [15:0]  beat_idx;
  logic         busy;
  logic         dma_start;
  logic [31:0]  dma_addr;
  logic         dma_write;
  logic [255:0] dma_wdata;
  logic         dma_done;
  logic [255:0] dma_rdata;

  logic [255:0] w [3];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tile_dma_scheduler #(
    .BEAT_BYTES(32),
    .CNT_W     (16)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .req_addr (req_addr),
    .req_beats(req_beats),
    .req_write(req_write),
    .wr_data  (wr_data),
    .gnt      (gnt),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .beat_idx (beat_idx),
    .busy     (busy),
    .dma_start(dma_start),
    .dma_addr (dma_addr),
    .dma_write(dma_write),
    .dma_wdata(dma_wdata),
    .dma_done (dma_done),
    .dma_rdata(dma_rdata)
  );

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // ISSUE cycle then a WAIT cycle that completes immediately.
  task automatic beat(input logic [2:0] eg, input logic [31:0] ea,
                      input logic [15:0] ei, input logic ew,
                      input logic [255:0] ewd, input logic [2:0] erv);
    tick;
    dma_done = 1'b0;
    chk("start", 256'(dma_start), 256'(1'b1));
    chk("gnt", 256'(gnt), 256'(eg));
    chk("addr", 256'(dma_addr), 256'(ea));
    chk("idx", 256'(beat_idx), 256'(ei));
    chk("dir", 256'(dma_write), 256'(ew));
    chk("wdata", dma_wdata, ewd);
    tick;
    dma_rdata = {8{ea ^ 32'h5A5A_0000}};
    dma_done  = 1'b1;
    #1;
    chk("start_w", 256'(dma_start), 256'(1'b0));
    chk("rdv", 256'(rd_valid), 256'(erv));
    chk("rdata", rd_data, {8{ea ^ 32'h5A5A_0000}});
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_gnt"}, 256'(gnt), 256'(3'b000));
    chk({tag, "_busy"}, 256'(busy), 256'(1'b0));
    chk({tag, "_done"}, 256'(done), 256'(3'b000));
    chk({tag, "_start"}, 256'(dma_start), 256'(1'b0));
    chk({tag, "_idx"}, 256'(beat_idx), 256'(16'd0));
    chk({tag, "_rdv"}, 256'(rd_valid), 256'(3'b000));
  endtask

  initial begin
    int order [4] = '{0, 1, 2, 0};
    logic [2:0]  oh;
    logic [31:0] base;

    w[0] = {8{32'hA0A0_0001}};
    w[1] = {8{32'hB1B1_0002}};
    w[2] = {8{32'hC2C2_0003}};
    wr_data   = {w[2], w[1], w[0]};
    rstn      = 1'b0;
    req       = '0;
    req_addr  = '0;
    req_beats = '0;
    req_write = '0;
    dma_done  = 1'b0;
    dma_rdata = '0;
    tick;
    tick;
    reset_checks("rst");

    // single read: requester 0, 3 beats at 0x1000
    rstn            = 1'b1;
    req_addr[31:0]  = 32'h1000;
    req_beats[15:0] = 16'd3;
    req             = 3'b001;
    beat(3'b001, 32'h1000, 16'd0, 1'b0, w[0], 3'b001);
    beat(3'b001, 32'h1020, 16'd1, 1'b0, w[0], 3'b001);
    beat(3'b001, 32'h1040, 16'd2, 1'b0, w[0], 3'b001);
    tick;
    dma_done = 1'b0;
    chk("rd_done", 256'(done), 256'(3'b001));
    chk("rd_busy", 256'(busy), 256'(1'b1));
    req = 3'b000;
    tick;
    chk("rd_idle_busy", 256'(busy), 256'(1'b0));
    chk("rd_idle_gnt", 256'(gnt), 256'(3'b000));
    chk("rd_idle_done", 256'(done), 256'(3'b000));

    // round-robin with all three held from reset
    rstn = 1'b0;
    tick;
    rstn      = 1'b1;
    req_addr  = {32'h300, 32'h200, 32'h100};
    req_beats = {16'd2, 16'd2, 16'd2};
    req       = 3'b111;
    for (int i = 0; i < 4; i++) begin
      oh   = 3'(1 << order[i]);
      base = 32'h100 * 32'(order[i] + 1);
      beat(oh, base, 16'd0, 1'b0, w[order[i]], oh);
      beat(oh, base + 32'h20, 16'd1, 1'b0, w[order[i]], oh);
      tick;
      dma_done = 1'b0;
      chk("rr_done", 256'(done), 256'(oh));
      chk("rr_gnt", 256'(gnt), 256'(oh));
      if (i == 3) req = 3'b000;
      tick;
      chk("rr_idle_gnt", 256'(gnt), 256'(3'b000));
      chk("rr_idle_busy", 256'(busy), 256'(1'b0));
    end

    // write path: requester 2, 2 beats
    req_addr[95:64]  = 32'h2000;
    req_beats[47:32] = 16'd2;
    req_write        = 3'b100;
    req              = 3'b100;
    beat(3'b100, 32'h2000, 16'd0, 1'b1, w[2], 3'b000);
    beat(3'b100, 32'h2020, 16'd1, 1'b1, w[2], 3'b000);
    tick;
    dma_done = 1'b0;
    chk("wr_done", 256'(done), 256'(3'b100));
    req       = 3'b000;
    req_write = 3'b000;
    tick;
    chk("wr_idle", 256'(busy), 256'(1'b0));

    // zero beats on requester 1
    req_beats[31:16] = 16'd0;
    req              = 3'b010;
    tick;
    chk("z_gnt", 256'(gnt), 256'(3'b010));
    chk("z_done", 256'(done), 256'(3'b010));
    chk("z_start", 256'(dma_start), 256'(1'b0));
    chk("z_busy", 256'(busy), 256'(1'b1));
    req = 3'b000;
    tick;
    chk("z_idle_gnt", 256'(gnt), 256'(3'b000));
    chk("z_idle_done", 256'(done), 256'(3'b000));
    chk("z_idle_start", 256'(dma_start), 256'(1'b0));

    // address wrap on requester 0
    req_addr[31:0]  = 32'hFFFF_FFE0;
    req_beats[15:0] = 16'd2;
    req             = 3'b001;
    beat(3'b001, 32'hFFFF_FFE0, 16'd0, 1'b0, w[0], 3'b001);
    beat(3'b001, 32'h0000_0000, 16'd1, 1'b0, w[0], 3'b001);
    tick;
    dma_done = 1'b0;
    chk("wrap_done", 256'(done), 256'(3'b001));
    req = 3'b000;
    tick;

    // stray dma_done in IDLE and in ISSUE
    dma_done = 1'b1;
    #1;
    chk("s_idle_rdv", 256'(rd_valid), 256'(3'b000));
    tick;
    chk("s_idle_busy", 256'(busy), 256'(1'b0));
    chk("s_idle_start", 256'(dma_start), 256'(1'b0));
    req_addr[31:0] = 32'h3000;
    req            = 3'b001;
    tick;
    chk("s_iss_start", 256'(dma_start), 256'(1'b1));
    #1;
    chk("s_iss_rdv", 256'(rd_valid), 256'(3'b000));
    tick;
    dma_done = 1'b0;
    chk("s_wait_idx", 256'(beat_idx), 256'(16'd0));
    chk("s_wait_addr", 256'(dma_addr), 256'(32'h3000));
    chk("s_wait_start", 256'(dma_start), 256'(1'b0));
    chk("s_wait_busy", 256'(busy), 256'(1'b1));
    tick;
    dma_done = 1'b1;
    #1;
    chk("s_rdv", 256'(rd_valid), 256'(3'b001));
    beat(3'b001, 32'h3020, 16'd1, 1'b0, w[0], 3'b001);
    tick;
    dma_done = 1'b0;
    chk("s_done", 256'(done), 256'(3'b001));
    req = 3'b000;
    tick;

    // reset in WAIT of beat 2 of 4; requester 1 raised meanwhile
    req_addr[31:0]  = 32'h4000;
    req_beats[15:0] = 16'd4;
    req_addr[63:32] = 32'h5000;
    req_beats[31:16] = 16'd1;
    req             = 3'b001;
    beat(3'b001, 32'h4000, 16'd0, 1'b0, w[0], 3'b001);
    tick;
    dma_done = 1'b0;
    chk("m_addr2", 256'(dma_addr), 256'(32'h4020));
    chk("m_idx2", 256'(beat_idx), 256'(16'd1));
    req = 3'b011;
    tick;
    rstn = 1'b0;
    tick;
    reset_checks("mrst");
    rstn = 1'b1;
    beat(3'b001, 32'h4000, 16'd0, 1'b0, w[0], 3'b001);
    beat(3'b001, 32'h4020, 16'd1, 1'b0, w[0], 3'b001);
    beat(3'b001, 32'h4040, 16'd2, 1'b0, w[0], 3'b001);
    beat(3'b001, 32'h4060, 16'd3, 1'b0, w[0], 3'b001);
    tick;
    dma_done = 1'b0;
    chk("m_done0", 256'(done), 256'(3'b001));
    req = 3'b010;
    tick;
    beat(3'b010, 32'h5000, 16'd0, 1'b0, w[1], 3'b010);
    tick;
    dma_done = 1'b0;
    chk("m_done1", 256'(done), 256'(3'b010));
    req = 3'b000;
    tick;
    chk("m_end_busy", 256'(busy), 256'(1'b0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tile_dma_scheduler.md
# tile_dma_scheduler

Shares the accelerator's single DMA channel between three requesters: the A-tile loader (0), the B-tile loader (1) and the C-tile writeback (2). Each requester asks for a multi-beat transfer (base address, beat count, direction). The scheduler arbitrates round-robin, issues the transfer to the DMA one 256-bit beat at a time, steers read data back to the winner and signals completion. It sits between the tile sequencing logic and the DMA engine, replacing direct `dma_start` drive by the loaders.

## Interface
- `BEAT_BYTES`, 32: byte address increment per beat (one 256-bit word).
- `CNT_W`, 16: width of the per-requester beat count.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `req` in 3: request per requester, level; held until the matching `done`.
- `req_addr` in 96: base byte address; requester i uses bits [32i+31:32i].
- `req_beats` in 3*CNT_W: beat count; requester i uses slice i.
- `req_write` in 3: 1 = write to memory, 0 = read.
- `wr_data` in 768: write beat per requester; slice i is 256 bits.
- `gnt` out 3: one-hot grant, registered.
- `done` out 3: one-cycle completion pulse per requester.
- `rd_data` out 256: `dma_rdata` pass-through.
- `rd_valid` out 3: read beat strobe for the granted reader.
- `beat_idx` out CNT_W: index of the current beat within the grant.
- `busy` out 1: high whenever the state is not IDLE.
- `dma_start` out 1: one-cycle beat launch.
- `dma_addr` out 32: beat byte address, valid while `dma_start` is high.
- `dma_write` out 1: direction of the current beat.
- `dma_wdata` out 256: the granted requester's `wr_data` slice.
- `dma_done` in 1: beat complete, one-cycle pulse.
- `dma_rdata` in 256: read beat, valid with `dma_done`.

## Operation
States:
- IDLE: no grant held.
- ISSUE: `dma_start` = 1 for exactly this one cycle.
- WAIT: waiting for `dma_done`.
- DONE: `done[g]` = 1 for this one cycle.

Arbitration (only in IDLE, on sampled `req`):
- The winner is the first set bit searching from `(last+1) mod 3` upward, wrapping.
- `last` resets to 2, so requester 0 has first priority after reset.
- On the IDLE clock edge with a winner, the scheduler latches `g`, `cur_addr = req_addr[g]`, `remaining = req_beats[g]` and `dir = req_write[g]`. It also sets `gnt[g]` and `beat_idx = 0`.
- Next state is ISSUE, or DONE if `remaining == 0` (no DMA activity).

Transfer:
- WAIT on `dma_done`: `cur_addr += BEAT_BYTES` (modulo 2^32, wraps silently), `remaining -= 1`, `beat_idx += 1`.
- Next state is DONE if the pre-decrement `remaining == 1`, else ISSUE.
- DONE: pulse `done[g]`, set `last = g`, next state IDLE. `gnt` clears on the DONE-to-IDLE edge.

Output rules:
- `rd_valid[i] = dma_done & (state == WAIT) & gnt[i] & ~dir`. Writes never raise `rd_valid`.
- `dma_addr = cur_addr`, `dma_write = dir`, `dma_wdata = wr_data` slice g. These are held constant from ISSUE through WAIT.

Boundary rules:
- `dma_done` is ignored outside WAIT, including when it coincides with the ISSUE cycle.
- Changes to `req`, `req_addr`, `req_beats` or `req_write` are ignored after the grant. The transfer always runs to completion.
- A requester whose `req` is still high in IDLE after its `done` competes again, but round-robin places it last.
- Reset in any state: state IDLE, `gnt` = 0, `done` = 0, `dma_start` = 0, `beat_idx` = 0, `busy` = 0, `last` = 2, internal counters 0. Any beat in flight is abandoned.

## Timing
- Request high in IDLE at edge 0: `gnt`/`busy` rise and `dma_start` = 1 during cycle 1; WAIT from cycle 2.
- `dma_done` during cycle t: the next `dma_start` is in cycle t+1 for a middle beat, or `done` is in cycle t+1 for the last beat.
- After `done` in cycle t+1, the state is IDLE in cycle t+2 and a new grant is visible in cycle t+3.
- Minimum per-beat period: 2 cycles (ISSUE plus a WAIT with immediate done).
- Minimum transaction overhead: 3 cycles (IDLE arbitration, first ISSUE, DONE).
- Zero-beat request: `gnt` is high in cycle 1 and `done` pulses in cycle 1.
- All outputs except `rd_valid`, `rd_data` and `dma_wdata` are registered or decoded from registered state.

## Test plan
- **Single read:** requester 0 reads 3 beats at 0x1000, DMA done 1 cycle after each start. Required: `dma_addr` 0x1000/0x1020/0x1040; 3 `rd_valid[0]` pulses; `beat_idx` 0,1,2; `done[0]` 1 cycle after the third `dma_done`.
- **Round-robin:** all three `req` high (2 beats each) from reset and held. Required: grant order 0,1,2,0; no grant overlaps; each `done` is followed by IDLE before the next `gnt`.
- **Write path:** requester 2 writes 2 beats. Required: `dma_write` = 1; `dma_wdata` equals slice 2 of `wr_data`; `rd_valid` stays 0.
- **Zero beats and wrap:** requester 1 with beats = 0 gets `done[1]` with no `dma_start`. Requester 0 at 0xFFFFFFE0 with 2 beats gets `dma_addr` 0xFFFFFFE0 then 0x00000000.
- **Stray done:** `dma_done` asserted during ISSUE and during IDLE. Required: no count change and no `rd_valid`.
- **Reset mid-transfer:** `rstn` low in WAIT of beat 2 of 4. Required: all outputs return to reset values next cycle; after release, requester 0 wins first and restarts at its base address.
